uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Serial UART transmitter directly downstream of the NIOS II TX data PIO. It captures the 8-bit byte on the PIO's `out_port` when software pulses a start PIO bit, then shifts it out on `tx` as start, data (LSB first), optional parity and stop bits. Its `tx_busy` status is returned to software through an input PIO for polling.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per bit period (50 MHz / 115200 baud); legal range 2..65535.
- `PARITY_EN`, 0: 1 inserts one parity bit after D7.
- `PARITY_ODD`, 0: parity sense when enabled; 0 is even, 1 is odd.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send; driven by the TX data PIO `out_port`.
- `tx_start`  in  1  start request from the control PIO; level input, rising-edge detected internally.
- `tx`  out  1  serial line; idle high.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- Edge detect:
  - `start_q` registers `tx_start` every cycle.
  - `start_rise = tx_start & ~start_q`.
  - `start_q` resets to 1, so a level already high through reset does not start a frame; a fresh 0→1 transition is required.
- States: IDLE, START, DATA, PARITY, STOP. A bit counter spans 0..CLKS_PER_BIT-1; a data index spans 0..7.
- IDLE:
  - `tx`=1, `tx_busy`=0.
  - On `start_rise`: latch `tx_data` into the shift register, compute parity from the latched byte, clear the counters, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0; shift right at the end of each bit period.
  - After index 7 completes, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: `tx` = XOR of the latched byte, inverted if `PARITY_ODD`; lasts one bit period, then go to STOP.
- STOP:
  - `tx`=1 for STOP_BITS × CLKS_PER_BIT cycles.
  - Then go to IDLE and assert `tx_done` for exactly one cycle.
- `tx_data` is sampled only on the accepting cycle. Later PIO writes do not affect the frame in flight.
- A `start_rise` while not in IDLE is ignored and not queued. `start_q` still tracks the input, so that edge is consumed.
- `tx_busy` = (state != IDLE), decoded from the registered state.
- `tx` is driven from a register, so there are no glitches.
- Reset values, applied from the cycle after `reset` is sampled high:
  - state=IDLE, `tx`=1, `tx_busy`=0, `tx_done`=0.
  - Shift register=0, counters=0.
- Reset mid-frame aborts immediately; `tx` returns high on the next edge and no `tx_done` is issued.

## Timing
- `start_rise` sampled at edge N:
  - At edge N+1, state=START, `tx`=0, `tx_busy`=1.
- Each bit lasts exactly CLKS_PER_BIT cycles, with no drift between bits.
- Frame length F = (1 + 8 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, measured from `tx` falling to return to IDLE.
- At edge N+1+F: state=IDLE, `tx_busy`=0, `tx_done`=1 for one cycle.
- Back-to-back frames:
  - A `start_rise` sampled in the `tx_done` cycle (state=IDLE) is accepted.
  - The new start bit begins the following cycle, so minimum frame spacing is F+1 cycles.
- Software sequence: write the data PIO, then toggle start 0→1. Data must be stable at least one cycle before the start edge; the PIO path guarantees this.

## Test plan
- Reset then idle (CLKS_PER_BIT=4): hold `reset` 3 cycles with `tx_start`=1 → `tx`=1, `tx_busy`=0, `tx_done`=0. After release, no frame starts until `tx_start` goes 0 then 1.
- Basic frame (CLKS_PER_BIT=4, no parity, 1 stop):
  - Stimulus: `tx_data`=0xA5, then start edge.
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `tx_busy` is high 40 cycles; `tx_done` pulses once at cycle 41.
- Parity and 2 stop bits (PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2):
  - Stimulus: 0x07.
  - Parity bit = 1; frame length 12×4 = 48 cycles.
  - Repeat with PARITY_ODD=1 → parity bit = 0.
- Busy rejection and data stability:
  - Stimulus: change `tx_data` to 0xFF and give a second start edge mid-frame.
  - The current byte 0x3C transmits unchanged; no second frame starts; exactly one `tx_done`.
- Back-to-back: start edge in the `tx_done` cycle with 0x55 queued → `tx` falls the next cycle; idle gap between frames is 1 cycle.
- Reset mid-frame: assert `reset` during DATA bit 3 → next cycle `tx`=1, `tx_busy`=0, no `tx_done`; a subsequent frame with 0x81 is bit-exact.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmitter fed by the NIOS II TX data PIO.
// A fresh rising edge on tx_start captures tx_data and sends one frame:
// start bit, eight data bits LSB first, optional parity, then one or two
// stop bits. tx_busy is read back by software for polling and tx_done
// pulses for one cycle when the frame completes.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
   localparam logic        STOP_LAST = (STOP_BITS == 2);
   localparam logic        PAR_ODD   = (PARITY_ODD != 0);
   localparam logic        PAR_EN    = (PARITY_EN != 0);

   state_t      r_state;
   logic [15:0] r_bitCnt;
   logic [2:0]  r_dataIdx;
   logic        r_stopIdx;
   logic [7:0]  r_shift;
   logic        r_parity;
   logic        r_tx;
   logic        r_done;
   logic        r_startQ;

   state_t      w_stateNext;
   logic [15:0] w_bitCntNext;
   logic [2:0]  w_dataIdxNext;
   logic        w_stopIdxNext;
   logic [7:0]  w_shiftNext;
   logic        w_parityNext;
   logic        w_txNext;
   logic        w_doneNext;
   logic        w_startRise;
   logic        w_bitEnd;

   assign w_startRise = tx_start & ~r_startQ;
   assign w_bitEnd    = (r_bitCnt == LAST_CNT);

   // Next-state logic for the frame sequencer. The bit counter runs in every
   // non-idle state and wraps at the end of each bit period, so every bit is
   // exactly CLKS_PER_BIT cycles long with no accumulated drift. The serial
   // line value is derived from the next state so that tx can be registered
   // and still change on the same edge as the state.
   always_comb begin
      w_stateNext   = r_state;
      w_bitCntNext  = r_bitCnt;
      w_dataIdxNext = r_dataIdx;
      w_stopIdxNext = r_stopIdx;
      w_shiftNext   = r_shift;
      w_parityNext  = r_parity;
      w_doneNext    = 1'b0;
      w_txNext      = 1'b1;

      if (r_state != IDLE) begin
         w_bitCntNext = w_bitEnd ? 16'd0 : r_bitCnt + 16'd1;
      end

      case (r_state)
         IDLE: begin
            if (w_startRise) begin
               w_stateNext   = START;
               w_shiftNext   = tx_data;
               w_parityNext  = (^tx_data) ^ PAR_ODD;
               w_bitCntNext  = 16'd0;
               w_dataIdxNext = 3'd0;
               w_stopIdxNext = 1'b0;
            end
         end
         START: begin
            if (w_bitEnd) begin
               w_stateNext = DATA;
            end
         end
         DATA: begin
            if (w_bitEnd) begin
               w_shiftNext = {1'b0, r_shift[7:1]};
               if (r_dataIdx == 3'd7) begin
                  w_stateNext   = PAR_EN ? PARITY : STOP;
                  w_dataIdxNext = 3'd0;
               end else begin
                  w_dataIdxNext = r_dataIdx + 3'd1;
               end
            end
         end
         PARITY: begin
            if (w_bitEnd) begin
               w_stateNext = STOP;
            end
         end
         STOP: begin
            if (w_bitEnd) begin
               if (r_stopIdx == STOP_LAST) begin
                  w_stateNext   = IDLE;
                  w_doneNext    = 1'b1;
                  w_stopIdxNext = 1'b0;
               end else begin
                  w_stopIdxNext = 1'b1;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase

      case (w_stateNext)
         START:   w_txNext = 1'b0;
         DATA:    w_txNext = w_shiftNext[0];
         PARITY:  w_txNext = w_parityNext;
         default: w_txNext = 1'b1;
      endcase
   end

   // State and datapath registers. Reset aborts any frame in flight, forces
   // the line high and suppresses tx_done. The start edge detector resets to
   // one so that a start level held high through reset cannot launch a frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_bitCnt  <= 16'd0;
         r_dataIdx <= 3'd0;
         r_stopIdx <= 1'b0;
         r_shift   <= 8'd0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
         r_done    <= 1'b0;
         r_startQ  <= 1'b1;
      end else begin
         r_state   <= w_stateNext;
         r_bitCnt  <= w_bitCntNext;
         r_dataIdx <= w_dataIdxNext;
         r_stopIdx <= w_stopIdxNext;
         r_shift   <= w_shiftNext;
         r_parity  <= w_parityNext;
         r_tx      <= w_txNext;
         r_done    <= w_doneNext;
         r_startQ  <= tx_start;
      end
   end

   assign tx      = r_tx;
   assign tx_busy = (r_state != IDLE);
   assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer. Three instances with different framing
// options share one stimulus stream; a frame-level model predicts tx,
// tx_busy and tx_done for each instance every cycle.
module tb_uart_tx_serializer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_start = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic [2:0] txW;
   logic [2:0] busyW;
   logic [2:0] doneW;

   int total = 0;
   int bad = 0;

   int         mPos[3];
   logic [7:0] mData[3];
   logic       mDone[3];
   logic       mPrevStart;
   logic       modelLive = 1'b0;

   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dutA (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
      .tx(txW[0]), .tx_busy(busyW[0]), .tx_done(doneW[0]));

   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dutB (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
      .tx(txW[1]), .tx_busy(busyW[1]), .tx_done(doneW[1]));

   uart_tx_serializer #(.CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dutC (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
      .tx(txW[2]), .tx_busy(busyW[2]), .tx_done(doneW[2]));

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   function automatic int cfgCpb(input int i);
      return (i == 2) ? 5 : 4;
   endfunction

   function automatic int cfgPe(input int i);
      return (i == 0) ? 0 : 1;
   endfunction

   function automatic int cfgOdd(input int i);
      return (i == 2) ? 1 : 0;
   endfunction

   function automatic int cfgStop(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic int frameLen(input int i);
      return (9 + cfgPe(i) + cfgStop(i)) * cfgCpb(i);
   endfunction

   // Value of bit slot k of a frame carrying d: start, data LSB first,
   // optional parity, then stop bits.
   function automatic logic frameBit(input int i, input logic [7:0] d, input int k);
      logic p;
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      p = (^d) ^ (cfgOdd(i) != 0);
      if (k == 9 && cfgPe(i) != 0) return p;
      return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic s, input logic r);
      @(negedge clk);
      tx_data  = d;
      tx_start = s;
      reset    = r;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sendByte(input logic [7:0] d);
      applyStimulus(d, 1'b0, 1'b0);
      applyStimulus(d, 1'b1, 1'b0);
   endtask

   task automatic waitAllIdle(input int budget, input string name);
      int n;
      n = 0;
      while (busyW != 3'b000 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busyW != 3'b000) checkOutput(name, 32'(busyW), 32'd0);
   endtask

   // Frame-level model plus per-cycle comparison. Each instance is either
   // idle or at cycle position mPos inside a frame; the expected line value
   // is the frame bit at slot mPos / CLKS_PER_BIT.
   initial begin : modelAndCompare
      logic rise;
      logic expTx;
      for (int i = 0; i < 3; i++) begin
         mPos[i] = -1;
         mDone[i] = 1'b0;
         mData[i] = 8'h00;
      end
      mPrevStart = 1'b1;
      forever begin
         @(posedge clk);
         if (reset) begin
            for (int i = 0; i < 3; i++) begin
               mPos[i] = -1;
               mDone[i] = 1'b0;
            end
            mPrevStart = 1'b1;
            modelLive = 1'b1;
         end else begin
            rise = tx_start && !mPrevStart;
            for (int i = 0; i < 3; i++) begin
               mDone[i] = 1'b0;
               if (mPos[i] < 0) begin
                  if (rise) begin
                     mPos[i] = 0;
                     mData[i] = tx_data;
                  end
               end else begin
                  mPos[i]++;
                  if (mPos[i] == frameLen(i)) begin
                     mPos[i] = -1;
                     mDone[i] = 1'b1;
                  end
               end
            end
            mPrevStart = tx_start;
         end
         #1;
         if (modelLive) begin
            for (int i = 0; i < 3; i++) begin
               expTx = (mPos[i] < 0) ? 1'b1 : frameBit(i, mData[i], mPos[i] / cfgCpb(i));
               checkOutput($sformatf("tx%0d", i), 32'(txW[i]), 32'(expTx));
               checkOutput($sformatf("busy%0d", i), 32'(busyW[i]), 32'(mPos[i] >= 0));
               checkOutput($sformatf("done%0d", i), 32'(doneW[i]), 32'(mDone[i]));
            end
         end
      end
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized frames.
   initial begin : stimulus
      logic [9:0] seen;
      logic [9:0] modelBits;
      logic       parB;
      logic       parC;
      int         busyCnt;
      int         doneCnt;
      int         doneAt;
      int         n;
      logic [7:0] d;

      parB = 1'b0;
      parC = 1'b0;

      $display("[TB] model pin checks");
      for (int k = 0; k < 10; k++) modelBits[k] = frameBit(0, 8'hA5, k);
      checkOutput("modelA5", 32'(modelBits), 32'h34A);
      checkOutput("modelParEven", 32'(frameBit(1, 8'h07, 9)), 32'd1);
      checkOutput("modelParOdd", 32'(frameBit(2, 8'h07, 9)), 32'd0);
      checkOutput("modelLenB", 32'(frameLen(1)), 32'd48);

      $display("[TB] reset with start held high");
      applyStimulus(8'h3C, 1'b1, 1'b1);
      idleCycles(3);
      checkOutput("rstTx", 32'(txW[0]), 32'd1);
      checkOutput("rstBusy", 32'(busyW[0]), 32'd0);
      checkOutput("rstDone", 32'(doneW[0]), 32'd0);
      applyStimulus(8'h3C, 1'b1, 1'b0);
      idleCycles(10);
      checkOutput("noStartAfterRst", 32'(busyW), 32'd0);

      $display("[TB] basic frame 0xA5");
      applyStimulus(8'hA5, 1'b0, 1'b0);
      applyStimulus(8'hA5, 1'b1, 1'b0);
      busyCnt = 0;
      doneCnt = 0;
      doneAt = -1;
      seen = '0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (busyW[0]) busyCnt++;
         if (doneW[0]) begin
            doneCnt++;
            doneAt = k;
         end
         if (k % 4 == 1 && k < 40) seen[k/4] = txW[0];
      end
      checkOutput("frameA5", 32'(seen), 32'h34A);
      checkOutput("busyLenA", 32'(busyCnt), 32'd40);
      checkOutput("doneCntA", 32'(doneCnt), 32'd1);
      checkOutput("doneAtA", 32'(doneAt), 32'd40);
      applyStimulus(8'hA5, 1'b0, 1'b0);
      waitAllIdle(100, "idleAfterA5");

      $display("[TB] parity frame 0x07");
      applyStimulus(8'h07, 1'b0, 1'b0);
      applyStimulus(8'h07, 1'b1, 1'b0);
      busyCnt = 0;
      doneCnt = 0;
      for (int k = 0; k < 65; k++) begin
         @(posedge clk);
         #1;
         if (busyW[1]) busyCnt++;
         if (doneW[1]) doneCnt++;
         if (k == 37) parB = txW[1];
         if (k == 46) parC = txW[2];
      end
      checkOutput("parityEven", 32'(parB), 32'd1);
      checkOutput("parityOdd", 32'(parC), 32'd0);
      checkOutput("busyLenB", 32'(busyCnt), 32'd48);
      checkOutput("doneCntB", 32'(doneCnt), 32'd1);
      waitAllIdle(100, "idleAfter07");

      $display("[TB] busy rejection 0x3C");
      sendByte(8'h3C);
      idleCycles(10);
      applyStimulus(8'hFF, 1'b0, 1'b0);
      applyStimulus(8'hFF, 1'b1, 1'b0);
      doneCnt = 0;
      for (int k = 0; k < 70; k++) begin
         @(posedge clk);
         #1;
         if (doneW[0]) doneCnt++;
      end
      checkOutput("rejectDoneCnt", 32'(doneCnt), 32'd1);
      checkOutput("rejectIdle", 32'(busyW), 32'd0);

      $display("[TB] back-to-back frames");
      sendByte(8'h5A);
      idleCycles(2);
      applyStimulus(8'h55, 1'b0, 1'b0);
      n = 0;
      while (!doneW[0] && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (doneW[0]) begin
         checkOutput("gapTx", 32'(txW[0]), 32'd1);
         tx_start = 1'b1;
         @(posedge clk);
         #1;
         checkOutput("b2bTx", 32'(txW[0]), 32'd0);
         checkOutput("b2bBusy", 32'(busyW[0]), 32'd1);
      end else begin
         checkOutput("b2bTimeout", 32'd0, 32'd1);
      end
      waitAllIdle(150, "idleAfterB2B");

      $display("[TB] reset during data bit 3");
      sendByte(8'hC3);
      repeat (17) @(posedge clk);
      applyStimulus(8'hC3, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("midRstTx", 32'(txW[0]), 32'd1);
      checkOutput("midRstBusy", 32'(busyW[0]), 32'd0);
      checkOutput("midRstDone", 32'(doneW[0]), 32'd0);
      applyStimulus(8'h81, 1'b0, 1'b0);
      idleCycles(2);
      applyStimulus(8'h81, 1'b1, 1'b0);
      idleCycles(3);
      checkOutput("postRstBusy", 32'(busyW[0]), 32'd1);
      waitAllIdle(100, "idleAfter81");

      $display("[TB] randomized frames");
      for (int it = 0; it < 30; it++) begin
         d = 8'($urandom);
         applyStimulus(d, 1'b0, 1'b0);
         idleCycles($urandom_range(0, 70));
         applyStimulus(d, 1'b1, 1'b0);
         idleCycles($urandom_range(1, 30));
         tx_data = 8'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            applyStimulus(tx_data, 1'b1, 1'b1);
            idleCycles($urandom_range(0, 2));
         end
      end
      applyStimulus(8'h00, 1'b0, 1'b0);
      waitAllIdle(100, "idleAtEnd");
      idleCycles(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
